// File: rtl/duck_motion_if.sv
// Frame-side handshake between the duck motion controller, the timing chain,
// the shot detector and the sprite-draw stage.
interface duck_motion_if;
   logic        vblnk_in;
   logic        start;
   logic        hit;
   logic [10:0] xpos;
   logic [10:0] ypos;
   logic        invert;
   logic [2:0]  state_out;
   logic        escaped;
   logic        landed;

   modport slave (
      input  vblnk_in, start, hit,
      output xpos, ypos, invert, state_out, escaped, landed
   );

   modport master (
      output vblnk_in, start, hit,
      input  xpos, ypos, invert, state_out, escaped, landed
   );
endinterface

// File: rtl/duck_motion_ctl.sv
// Per-frame motion controller for one duck sprite: bouncing flight, escape climb,
// hit freeze and fall. Position only moves on the rising edge of vertical blank.
//
// state  | meaning
// IDLE   | no duck on screen, outputs hold
// FLY    | bouncing flight between the screen bounds
// ESCAPE | straight climb off the top of the screen
// HIT    | frozen after being shot
// FALL   | dropping to the ground line
module duck_motion_ctl #(
   parameter int X_MIN      = 0,
   parameter int X_MAX      = 752,
   parameter int Y_MIN      = 0,
   parameter int Y_FLOOR    = 450,
   parameter int START_X    = 376,
   parameter int START_Y    = 450,
   parameter int SPEED_X    = 3,
   parameter int SPEED_Y    = 2,
   parameter int FALL_SPEED = 5,
   parameter int FLY_FRAMES = 300,
   parameter int HIT_FRAMES = 30
) (
   input  logic          pclk,
   input  logic          rst_n,
   duck_motion_if.slave  duck
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FLY    = 3'd1,
      S_ESCAPE = 3'd2,
      S_HIT    = 3'd3,
      S_FALL   = 3'd4
   } state_t;

   localparam logic [11:0] XMIN_W  = 12'(X_MIN);
   localparam logic [11:0] XMAX_W  = 12'(X_MAX);
   localparam logic [11:0] YMIN_W  = 12'(Y_MIN);
   localparam logic [11:0] YFLR_W  = 12'(Y_FLOOR);
   localparam logic [11:0] SPDX_W  = 12'(SPEED_X);
   localparam logic [11:0] SPDY_W  = 12'(SPEED_Y);
   localparam logic [11:0] FALL_W  = 12'(FALL_SPEED);
   localparam logic [8:0]  FLY_END = 9'(FLY_FRAMES - 1);
   localparam logic [8:0]  HIT_END = 9'(HIT_FRAMES - 1);

   state_t      state_q;
   logic [10:0] x_q, y_q;
   logic        dir_left_q, dir_up_q;
   logic        invert_q, escaped_q, landed_q, vblnk_q;
   logic [8:0]  frame_cnt_q;

   logic        tick;
   logic [11:0] x_ext, y_ext;
   logic [10:0] x_fly_d, y_fly_d;
   logic        dir_left_d, dir_up_d;

   assign tick  = duck.vblnk_in & ~vblnk_q;
   assign x_ext = {1'b0, x_q};
   assign y_ext = {1'b0, y_q};

   // Next flight position; 12-bit compares catch wrap below 0 via the bound+step test.
   always_comb begin
      x_fly_d    = x_q;
      y_fly_d    = y_q;
      dir_left_d = dir_left_q;
      dir_up_d   = dir_up_q;
      if (!dir_left_q) begin
         if (x_ext + SPDX_W >= XMAX_W) begin
            x_fly_d    = XMAX_W[10:0];
            dir_left_d = 1'b1;
         end else begin
            x_fly_d = 11'(x_ext + SPDX_W);
         end
      end else if (x_ext < XMIN_W + SPDX_W) begin
         x_fly_d    = XMIN_W[10:0];
         dir_left_d = 1'b0;
      end else begin
         x_fly_d = 11'(x_ext - SPDX_W);
      end
      if (dir_up_q) begin
         if (y_ext < YMIN_W + SPDY_W) begin
            y_fly_d  = YMIN_W[10:0];
            dir_up_d = 1'b0;
         end else begin
            y_fly_d = 11'(y_ext - SPDY_W);
         end
      end else if (y_ext + SPDY_W >= YFLR_W) begin
         y_fly_d  = YFLR_W[10:0];
         dir_up_d = 1'b1;
      end else begin
         y_fly_d = 11'(y_ext + SPDY_W);
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         x_q         <= 11'(START_X);
         y_q         <= 11'(START_Y);
         dir_left_q  <= 1'b0;
         dir_up_q    <= 1'b1;
         invert_q    <= 1'b0;
         escaped_q   <= 1'b0;
         landed_q    <= 1'b0;
         vblnk_q     <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         vblnk_q   <= duck.vblnk_in;
         escaped_q <= 1'b0;
         landed_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (duck.start) begin
                  x_q         <= 11'(START_X);
                  y_q         <= 11'(START_Y);
                  dir_left_q  <= 1'b0;
                  dir_up_q    <= 1'b1;
                  frame_cnt_q <= '0;
                  state_q     <= S_FLY;
               end
            end
            S_FLY: begin
               if (duck.hit) begin
                  frame_cnt_q <= '0;
                  state_q     <= S_HIT;
               end else if (tick) begin
                  x_q        <= x_fly_d;
                  y_q        <= y_fly_d;
                  dir_left_q <= dir_left_d;
                  dir_up_q   <= dir_up_d;
                  invert_q   <= dir_left_d;
                  if (frame_cnt_q == FLY_END) begin
                     state_q <= S_ESCAPE;
                  end else begin
                     frame_cnt_q <= frame_cnt_q + 9'd1;
                  end
               end
            end
            S_ESCAPE: begin
               if (duck.hit) begin
                  frame_cnt_q <= '0;
                  state_q     <= S_HIT;
               end else if (tick) begin
                  // Leaving once the next step would land below SPEED_Y (or wrap).
                  if (y_ext < SPDY_W + SPDY_W) begin
                     y_q       <= '0;
                     escaped_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end else begin
                     y_q <= 11'(y_ext - SPDY_W);
                  end
               end
            end
            S_HIT: begin
               if (tick) begin
                  if (frame_cnt_q == HIT_END) begin
                     frame_cnt_q <= '0;
                     state_q     <= S_FALL;
                  end else begin
                     frame_cnt_q <= frame_cnt_q + 9'd1;
                  end
               end
            end
            S_FALL: begin
               if (tick) begin
                  if (y_ext + FALL_W >= YFLR_W) begin
                     y_q      <= YFLR_W[10:0];
                     landed_q <= 1'b1;
                     state_q  <= S_IDLE;
                  end else begin
                     y_q <= 11'(y_ext + FALL_W);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign duck.xpos      = x_q;
   assign duck.ypos      = y_q;
   assign duck.invert    = invert_q;
   assign duck.state_out = state_q;
   assign duck.escaped   = escaped_q;
   assign duck.landed    = landed_q;

endmodule

// File: tb/tb_duck_motion_ctl.sv
// Bench for duck_motion_ctl: directed scenarios plus random frames, all checked
// every cycle against a frame-rule model of the duck.
module tb_duck_motion_ctl;

   localparam int START_X = 376;
   localparam int START_Y = 450;
   localparam int X_MAX   = 752;
   localparam int Y_FLOOR = 450;
   localparam int M_IDLE = 0, M_FLY = 1, M_ESC = 2, M_HIT = 3, M_FALL = 4;

   logic pclk  = 1'b0;
   logic rst_n = 1'b1;
   duck_motion_if dif ();

   duck_motion_ctl dut (
      .pclk  (pclk),
      .rst_n (rst_n),
      .duck  (dif.slave)
   );

   always #5 pclk = ~pclk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int m_state, m_x, m_y, m_dx, m_dy, m_frames, m_inv, m_esc, m_land, m_vprev;
   int esc_seen, land_seen, x_changes, last_x;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE; m_x = START_X; m_y = START_Y; m_dx = 1; m_dy = -1;
      m_frames = 0; m_inv = 0; m_esc = 0; m_land = 0; m_vprev = 0;
   endtask

   task automatic model_step(input bit v, input bit s, input bit h);
      bit tick;
      tick = v && !m_vprev;
      m_vprev = v;
      m_esc = 0;
      m_land = 0;
      if (m_state == M_IDLE) begin
         if (s) begin
            m_x = START_X; m_y = START_Y; m_dx = 1; m_dy = -1;
            m_frames = 0; m_state = M_FLY;
         end
      end else if (m_state == M_FLY || m_state == M_ESC) begin
         if (h) begin
            m_state = M_HIT; m_frames = 0;
         end else if (tick && m_state == M_FLY) begin
            m_x = m_x + 3 * m_dx;
            if (m_dx > 0 && m_x >= X_MAX) begin m_x = X_MAX; m_dx = -1; end
            else if (m_dx < 0 && m_x < 0) begin m_x = 0; m_dx = 1; end
            m_y = m_y + 2 * m_dy;
            if (m_dy > 0 && m_y >= Y_FLOOR) begin m_y = Y_FLOOR; m_dy = -1; end
            else if (m_dy < 0 && m_y < 0) begin m_y = 0; m_dy = 1; end
            m_inv = (m_dx < 0) ? 1 : 0;
            m_frames++;
            if (m_frames == 300) m_state = M_ESC;
         end else if (tick) begin
            m_y = m_y - 2;
            if (m_y < 2) begin m_y = 0; m_esc = 1; m_state = M_IDLE; end
         end
      end else if (m_state == M_HIT) begin
         if (tick) begin
            m_frames++;
            if (m_frames == 30) m_state = M_FALL;
         end
      end else if (m_state == M_FALL) begin
         if (tick) begin
            m_y = m_y + 5;
            if (m_y >= Y_FLOOR) begin m_y = Y_FLOOR; m_land = 1; m_state = M_IDLE; end
         end
      end
   endtask

   task automatic check_model();
      chk("xpos", int'(dif.xpos), m_x);
      chk("ypos", int'(dif.ypos), m_y);
      chk("invert", int'(dif.invert), m_inv);
      chk("state", int'(dif.state_out), m_state);
      chk("escaped", int'(dif.escaped), m_esc);
      chk("landed", int'(dif.landed), m_land);
   endtask

   // Starts and ends just after a falling clock edge.
   task automatic cyc(input bit v, input bit s, input bit h);
      dif.vblnk_in = v;
      dif.start    = s;
      dif.hit      = h;
      model_step(v, s, h);
      @(posedge pclk);
      #1;
      check_model();
      if (dif.escaped === 1'b1) esc_seen++;
      if (dif.landed === 1'b1) land_seen++;
      if (int'(dif.xpos) != last_x) x_changes++;
      last_x = int'(dif.xpos);
      @(negedge pclk);
   endtask

   task automatic run_frame(input int blank, input int active, input bit hit_tick, input bit rnd);
      for (int i = 0; i < blank + active; i++) begin
         bit v, s, h;
         v = (i < blank);
         s = 1'b0;
         h = hit_tick && (i == 0);
         if (rnd) begin
            s = ($urandom_range(0, 39) == 0);
            h = h || ($urandom_range(0, 1499) == 0);
         end
         cyc(v, s, h);
      end
   endtask

   task automatic run_frames(input int n);
      for (int i = 0; i < n; i++) run_frame(2, 4, 1'b0, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_x"}, int'(dif.xpos), START_X);
      chk({tag, "_y"}, int'(dif.ypos), START_Y);
      chk({tag, "_inv"}, int'(dif.invert), 0);
      chk({tag, "_state"}, int'(dif.state_out), M_IDLE);
      chk({tag, "_esc"}, int'(dif.escaped), 0);
      chk({tag, "_land"}, int'(dif.landed), 0);
   endtask

   int sx, sy, guard;

   initial begin
      dif.vblnk_in = 1'b0;
      dif.start    = 1'b0;
      dif.hit      = 1'b0;
      esc_seen = 0; land_seen = 0; x_changes = 0; last_x = START_X;
      model_reset();
      #2 rst_n = 1'b0;
      #1 check_reset_values("rst");
      @(negedge pclk);
      @(negedge pclk);
      rst_n = 1'b1;
      run_frames(2);

      // full flight, right bounce, escape
      cyc(1'b0, 1'b1, 1'b0);
      chk("start_state", int'(dif.state_out), M_FLY);
      run_frames(1);
      chk("first_x", int'(dif.xpos), 379);
      chk("first_y", int'(dif.ypos), 448);
      chk("first_inv", int'(dif.invert), 0);
      run_frames(125);
      chk("bounce_x", int'(dif.xpos), 752);
      chk("bounce_inv", int'(dif.invert), 1);
      run_frames(1);
      chk("after_bounce_x", int'(dif.xpos), 749);
      run_frames(173);
      chk("escape_state", int'(dif.state_out), M_ESC);
      esc_seen = 0;
      guard = 0;
      while (dif.state_out != 3'(M_IDLE) && guard < 300) begin run_frames(1); guard++; end
      chk("escape_timeout", int'(guard < 300), 1);
      chk("escape_y", int'(dif.ypos), 0);
      chk("escaped_pulses", esc_seen, 1);

      // hit coincident with tick, freeze, fall, land
      sx = int'(dif.xpos);
      cyc(1'b0, 1'b0, 1'b1);
      chk("idle_hit_state", int'(dif.state_out), M_IDLE);
      chk("idle_hit_x", int'(dif.xpos), sx);
      cyc(1'b0, 1'b1, 1'b0);
      run_frames(5);
      sx = int'(dif.xpos); sy = int'(dif.ypos);
      run_frame(2, 4, 1'b1, 1'b0);
      chk("hit_tick_x", int'(dif.xpos), sx);
      chk("hit_tick_y", int'(dif.ypos), sy);
      chk("hit_state", int'(dif.state_out), M_HIT);
      run_frames(29);
      chk("hit_hold_state", int'(dif.state_out), M_HIT);
      run_frames(1);
      chk("fall_state", int'(dif.state_out), M_FALL);
      land_seen = 0;
      guard = 0;
      while (dif.state_out != 3'(M_IDLE) && guard < 200) begin run_frames(1); guard++; end
      chk("land_timeout", int'(guard < 200), 1);
      chk("land_y", int'(dif.ypos), Y_FLOOR);
      chk("landed_pulses", land_seen, 1);

      // start ignored in flight, long vblank gives a single update
      cyc(1'b0, 1'b1, 1'b0);
      run_frames(3);
      sx = int'(dif.xpos);
      cyc(1'b0, 1'b1, 1'b0);
      chk("fly_start_x", int'(dif.xpos), sx);
      chk("fly_start_state", int'(dif.state_out), M_FLY);
      x_changes = 0;
      run_frame(12, 6, 1'b0, 1'b0);
      chk("long_vblank_updates", x_changes, 1);
      chk("long_vblank_x", int'(dif.xpos), sx + 3);

      // hit ignored while falling, then reset mid-fall
      run_frames(96);
      run_frame(2, 4, 1'b1, 1'b0);
      run_frames(33);
      chk("fall2_state", int'(dif.state_out), M_FALL);
      sy = int'(dif.ypos);
      cyc(1'b0, 1'b0, 1'b1);
      chk("fall_hit_state", int'(dif.state_out), M_FALL);
      chk("fall_hit_y", int'(dif.ypos), sy);
      run_frames(2);
      chk("fall_pre_reset_state", int'(dif.state_out), M_FALL);
      land_seen = 0;
      #2 rst_n = 1'b0;
      #1 check_reset_values("midrst");
      @(posedge pclk); #1 chk("midrst_land1", int'(dif.landed), 0);
      @(posedge pclk); #1 chk("midrst_land2", int'(dif.landed), 0);
      @(negedge pclk);
      model_reset();
      rst_n = 1'b1;
      last_x = int'(dif.xpos);

      // random frames, random start/hit pulses
      for (int f = 0; f < 2500; f++) begin
         run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), 1'b0, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/duck_motion_ctl.md
Name: duck_motion_ctl

Overview:
Per-frame motion controller for one duck sprite. Produces the xpos/ypos/invert inputs of the downstream sprite-draw stage in the VGA pipeline. Moves the duck in a bouncing flight pattern, then an escape climb, or a hit-freeze and fall when the shooter reports a hit. Updates positions only at the frame boundary so the sprite never tears during active video.

Parameters:
X_MIN, 0, left bound for xpos (pixels)
X_MAX, 752, right bound for xpos (screen width minus sprite width)
Y_MIN, 0, top bound during flight
Y_FLOOR, 450, ground line; the fall ends here
START_X, 376, xpos loaded on start and on reset
START_Y, 450, ypos loaded on start and on reset
SPEED_X, 3, horizontal step per frame
SPEED_Y, 2, vertical step per frame (flight and escape)
FALL_SPEED, 5, vertical step per frame while falling
FLY_FRAMES, 300, frames of flight before escape
HIT_FRAMES, 30, frames the duck is frozen after a hit

Ports:
pclk  input  1  pixel clock
rst_n  input  1  asynchronous reset, active low
vblnk_in  input  1  vertical blank from timing chain; its rising edge is the frame tick
start  input  1  one-cycle pulse; launches a duck
hit  input  1  one-cycle pulse from the shot detector
xpos  output  11  sprite left edge, to the draw stage
ypos  output  11  sprite top edge, to the draw stage
invert  output  1  1 = duck moving left (mirror sprite)
state_out  output  3  current state encoding, for the game FSM
escaped  output  1  one-cycle pulse when the duck leaves the top of the screen
landed  output  1  one-cycle pulse when the fall reaches Y_FLOOR

Behaviour:
- Reset (async assert, sync release): state IDLE; xpos=START_X; ypos=START_Y; invert=0; dir_x=right; dir_y=up; counters 0; escaped=landed=0.
- Frame tick: vblnk_d registered each cycle; tick = vblnk_in & ~vblnk_d. All position and counter updates happen on the clock edge where tick=1; outputs are therefore stable from 1 cycle after vblank start until the next tick.
- States (state_out): IDLE=0, FLY=1, ESCAPE=2, HIT=3, FALL=4.
- IDLE: outputs hold. start=1 -> load START_X/START_Y, dir_x=right, dir_y=up, frame_cnt=0, go to FLY on the next edge. start is ignored in every other state.
- FLY, on tick: x += or -= SPEED_X. If the result is >= X_MAX (or < X_MIN when going left), clamp to the bound and flip dir_x. y is handled the same way between Y_MIN and Y_FLOOR, flipping dir_y. frame_cnt++. When frame_cnt reaches FLY_FRAMES-1, go to ESCAPE.
- ESCAPE, on tick: x is unchanged; y -= SPEED_Y. If y < SPEED_Y, set y=0, pulse escaped for 1 cycle, and go to IDLE.
- hit=1 in FLY or ESCAPE (any cycle) -> HIT on the next edge; frame_cnt=0; position frozen. hit in IDLE, HIT or FALL is ignored.
- hit and tick in the same cycle: hit wins; no position update for that frame.
- HIT, on tick: frame_cnt++. At HIT_FRAMES-1, go to FALL.
- FALL, on tick: y += FALL_SPEED. If y >= Y_FLOOR, set y=Y_FLOOR, pulse landed for 1 cycle, and go to IDLE.
- invert = (dir_x == left). It is registered, changes only on tick, and is held in HIT and FALL.
- Arithmetic: all add/subtract and compare in 12 bits unsigned, so underflow below 0 and overflow past 2047 are caught by the clamp. Outputs are the low 11 bits of the clamped result.
- No tick while vblnk is held high; a new tick requires vblnk to drop and rise again.
- rst_n asserted mid-flight: immediate return to reset values; no escaped or landed pulse.

Test Plan:
- Reset, then start with no hit -> FLY. After 1 tick: xpos=379, ypos=448, invert=0. After 300 ticks: state=ESCAPE. ypos reaches 0, escaped pulses exactly once, state=IDLE.
- Right bounce: force x near X_MAX (start from START_X, run ~125 ticks) -> xpos clamps at 752, invert=1 on the same tick, next tick xpos=749.
- hit asserted in the same cycle as tick while in FLY -> position unchanged that frame; state=HIT. After 30 ticks: FALL. ypos rises by 5 per tick, clamps at 450; landed pulses once.
- hit pulses in IDLE and FALL, and start pulses in FLY -> no state or position change.
- vblnk_in held high for 3 lines -> exactly one update. Check that xpos is stable across active video between ticks.
- rst_n low mid-FALL for 2 cycles -> outputs immediately at reset values; state=IDLE; landed stays 0.
